// File: rtl/sram_access_scheduler_pkg.sv
// Shared definitions for the SRAM access scheduler: FSM states, requester
// identities and default timing constants.
package sram_access_scheduler_pkg;

    localparam int unsigned DEF_AW           = 19;
    localparam int unsigned DEF_DW           = 8;
    localparam int unsigned DEF_RD_CYCLES    = 2;
    localparam int unsigned DEF_WE_CYCLES    = 2;
    localparam int unsigned DEF_STARVE_LIMIT = 8;

    // Bit positions of each requester in the one-hot grant vector
    localparam int unsigned IDX_VID = 0;
    localparam int unsigned IDX_CPU = 1;
    localparam int unsigned IDX_LDR = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        REQ_VID = 2'd0,
        REQ_CPU = 2'd1,
        REQ_LDR = 2'd2
    } req_id_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_access_scheduler_prio_arbiter.sv
// Fixed-priority pick (video > CPU > loader) with a starvation counter that
// lets a long-waiting loader beat the CPU once. Grant is only produced while
// the scheduler reports IDLE.
module sram_prio_arbiter
    import sram_access_scheduler_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       idle_i,
    input  logic       vid_req_i,
    input  logic       cpu_req_i,
    input  logic       ldr_req_i,
    output logic [2:0] grant_o
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q, starve_d;
    logic          starved;

    assign starved = (starve_q == SW'(STARVE_LIMIT));

    // Priority pick; a starved loader jumps the CPU but never video
    always_comb begin
        grant_o = '0;
        if (idle_i) begin
            if (vid_req_i)                 grant_o[IDX_VID] = 1'b1;
            else if (ldr_req_i && starved) grant_o[IDX_LDR] = 1'b1;
            else if (cpu_req_i)            grant_o[IDX_CPU] = 1'b1;
            else if (ldr_req_i)            grant_o[IDX_LDR] = 1'b1;
        end
    end

    // Count losses of a waiting loader, saturating; clear when it wins or stops asking
    always_comb begin
        starve_d = starve_q;
        if (!ldr_req_i || grant_o[IDX_LDR]) begin
            starve_d = '0;
        end else if ((grant_o[IDX_VID] || grant_o[IDX_CPU]) && !starved) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

endmodule

// File: rtl/sram_access_scheduler.sv
// Shares one asynchronous SRAM port between video, CPU and loader. Sequences
// address setup, read sampling and the write-enable pulse; all pin outputs
// come straight from flops so sram_we_n cannot glitch.
module sram_access_scheduler
    import sram_access_scheduler_pkg::*;
#(
    parameter int unsigned AW           = DEF_AW,
    parameter int unsigned DW           = DEF_DW,
    parameter int unsigned RD_CYCLES    = DEF_RD_CYCLES,
    parameter int unsigned WE_CYCLES    = DEF_WE_CYCLES,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dout,
    output logic          sram_doe,
    input  logic [DW-1:0] sram_din,
    output logic          sram_we_n
);

    localparam int unsigned MAXC = max_u(RD_CYCLES, WE_CYCLES);
    localparam int unsigned CW   = $clog2(MAXC + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    req_id_e       id_q, id_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          we_n_q, we_n_d;
    logic          doe_q, doe_d;
    logic [2:0]    ack_q, ack_d;
    logic [2:0]    grant;
    logic          granted, grant_we;
    logic          rd_last, wr_last;

    assign granted  = |grant;
    assign grant_we = (grant[IDX_CPU] & cpu_we) | (grant[IDX_LDR] & ldr_we);
    assign rd_last  = (cnt_q == CW'(RD_CYCLES - 1));
    assign wr_last  = (cnt_q == CW'(WE_CYCLES - 1));

    sram_prio_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .idle_i    (state_q == ST_IDLE),
        .vid_req_i (vid_req),
        .cpu_req_i (cpu_req),
        .ldr_req_i (ldr_req),
        .grant_o   (grant)
    );

    // State and cycle-counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state sequencing of read and write accesses
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (granted) begin
                    cnt_d   = '0;
                    state_d = grant_we ? ST_WR_SETUP : ST_RD;
                end
            end
            ST_RD: begin
                if (rd_last) state_d = ST_DONE;
                else         cnt_d   = cnt_q + CW'(1);
            end
            ST_WR_SETUP: begin
                cnt_d   = '0;
                state_d = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (wr_last) state_d = ST_WR_HOLD;
                else         cnt_d   = cnt_q + CW'(1);
            end
            ST_WR_HOLD: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Pin and latch next values; pins are decoded from the next state so they settle on the flop edge
    always_comb begin
        we_n_d  = (state_d != ST_WR_PULSE);
        doe_d   = (state_d inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
        ack_d   = '0;
        id_d    = id_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        if (state_d == ST_DONE) begin
            case (id_q)
                REQ_VID: ack_d[IDX_VID] = 1'b1;
                REQ_CPU: ack_d[IDX_CPU] = 1'b1;
                REQ_LDR: ack_d[IDX_LDR] = 1'b1;
                default: ack_d = '0;
            endcase
        end
        if (state_q == ST_IDLE && granted) begin
            if (grant[IDX_VID]) begin
                id_d   = REQ_VID;
                addr_d = vid_addr;
            end else if (grant[IDX_CPU]) begin
                id_d   = REQ_CPU;
                addr_d = cpu_addr;
                if (cpu_we) dout_d = cpu_wdata;
            end else begin
                id_d   = REQ_LDR;
                addr_d = ldr_addr;
                if (ldr_we) dout_d = ldr_wdata;
            end
        end
        if (state_q == ST_RD && rd_last) rdata_d = sram_din;
    end

    // Registered outputs and grant latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q    <= REQ_VID;
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            we_n_q  <= 1'b1;
            doe_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            id_q    <= id_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            we_n_q  <= we_n_d;
            doe_q   <= doe_d;
            ack_q   <= ack_d;
        end
    end

    assign vid_ack   = ack_q[IDX_VID];
    assign cpu_ack   = ack_q[IDX_CPU];
    assign ldr_ack   = ack_q[IDX_LDR];
    assign rdata     = rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign sram_addr = addr_q;
    assign sram_dout = dout_q;
    assign sram_doe  = doe_q;
    assign sram_we_n = we_n_q;

endmodule
